// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STAT_WD = 16;

  function automatic int idx_wd(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_wd(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit above rr_last.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_WD  = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_WD-1:0]  rr_last,
  output logic [IDX_WD-1:0]  winner,
  output logic               found
);

  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDX_WD'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of the FIFO write port.
// Optional per-requester word counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_WD   = 8,
  parameter int MAX_BURST = 4,
  localparam int IDX_WD   = idx_wd(NUM_REQ),
  localparam int CNT_WD   = cnt_wd(MAX_BURST)
) (
  input  logic                       w_clk,
  input  logic                       w_resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  input  logic                       full_flag,
  output logic                       w_enbl,
  output logic [DATA_WD-1:0]         data_in,
  output logic                       busy,
  output logic [IDX_WD-1:0]          owner
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WD-1:0] stat_cnt
`endif
);

  arb_state_t        state, state_n;
  logic [IDX_WD-1:0] rr_last, rr_last_n;
  logic [IDX_WD-1:0] owner_n;
  logic [CNT_WD-1:0] burst_cnt, burst_cnt_n;
  logic [IDX_WD-1:0] winner;
  logic              found;
  logic              own_valid;
  logic              accept;
  logic              last_word;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_WD  (IDX_WD)
  ) u_pick (
    .req_valid (req_valid),
    .rr_last   (rr_last),
    .winner    (winner),
    .found     (found)
  );

  assign own_valid = req_valid[owner];
  assign accept    = w_resetn & (state == BURST)
                   & own_valid & ~full_flag;
  assign last_word = (burst_cnt == CNT_WD'(MAX_BURST - 1));
  assign w_enbl    = accept;
  assign busy      = (state == BURST);
  assign data_in   = req_data[int'(owner)*DATA_WD +: DATA_WD];

  always_comb begin
    req_ack = '0;
    if (accept) req_ack[owner] = 1'b1;
  end

  always_comb begin
    state_n     = state;
    rr_last_n   = rr_last;
    owner_n     = owner;
    burst_cnt_n = burst_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n     = BURST;
          owner_n     = winner;
          burst_cnt_n = '0;
        end
      end
      BURST: begin
        if (!own_valid) begin
          state_n     = IDLE;
          rr_last_n   = owner;
          burst_cnt_n = '0;
        end else if (!full_flag) begin
          if (last_word) begin
            state_n     = IDLE;
            rr_last_n   = owner;
            burst_cnt_n = '0;
          end else begin
            burst_cnt_n = burst_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      state     <= IDLE;
      rr_last   <= IDX_WD'(NUM_REQ - 1);
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      rr_last   <= rr_last_n;
      owner     <= owner_n;
      burst_cnt <= burst_cnt_n;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_WD-1:0] cnt;
    always_ff @(posedge w_clk) begin
      if (!w_resetn) cnt <= '0;
      else if (req_ack[i] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign stat_cnt[i*STAT_WD +: STAT_WD] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WD=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        full_flag;
  logic        w_enbl;
  logic [7:0]  data_in;
  logic        busy;
  logic [1:0]  owner;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WD   (8),
    .MAX_BURST (4)
  ) dut (
    .w_clk     (clk),
    .w_resetn  (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .full_flag (full_flag),
    .w_enbl    (w_enbl),
    .data_in   (data_in),
    .busy      (busy),
    .owner     (owner)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    full_flag = 1'b0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    full_flag = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0000 || w_enbl !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate: ack=%b wen=%b want 0000/0",
               req_ack, w_enbl);
    end
    next_cycle();
    req_valid = '0;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0 || w_enbl !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b owner=%0d wen=%b want 0/0/0",
               busy, owner, w_enbl);
    end
    next_cycle();
  endtask

  // Lone requester 0: exp_wen gives the write pattern per cycle.
  task automatic test_single_stream();
    logic [7:0] exp_wen;
    int nxt;
    do_reset();
    exp_wen   = 8'b1101_1110;
    nxt       = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      req_data[7:0] = 8'hA0 + 8'(nxt);
      @(negedge clk);
      checks++;
      if (w_enbl !== exp_wen[c]) begin
        errors++;
        $display("FAIL single_wen c%0d: got %b want %b",
                 c, w_enbl, exp_wen[c]);
      end
      if (exp_wen[c]) begin
        checks++;
        if (data_in !== 8'hA0 + 8'(nxt) || req_ack !== 4'b0001) begin
          errors++;
          $display("FAIL single_data c%0d: data=%h ack=%b want %h/0001",
                   c, data_in, req_ack, 8'hA0 + 8'(nxt));
        end
        nxt++;
      end
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (w_enbl !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drop: wen=%b busy=%b want 0/1", w_enbl, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b want 0", busy);
    end
    next_cycle();
  endtask

  // All four valid: 5-cycle period, idle slot then four writes.
  task automatic test_back_to_back();
    logic [1:0] eo;
    logic [3:0] ea;
    do_reset();
    req_data  = 32'h33_22_11_00;
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c % 5 == 0) begin
        checks++;
        if (w_enbl !== 1'b0 || req_ack !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_gap c%0d: wen=%b ack=%b want 0/0000",
                   c, w_enbl, req_ack);
        end
      end else begin
        eo = 2'((c / 5) % 4);
        ea = 4'b0001 << eo;
        checks++;
        if (w_enbl !== 1'b1 || owner !== eo || req_ack !== ea
            || data_in !== {2'b00, eo, 2'b00, eo}) begin
          errors++;
          $display("FAIL b2b_wr c%0d: wen=%b own=%0d ack=%b d=%h want 1/%0d/%b",
                   c, w_enbl, owner, req_ack, data_in, eo, ea);
        end
      end
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_full_stall();
    logic [9:0] exp_wen;
    logic [9:0] full_pat;
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h00_2C_00_00;
    exp_wen   = 10'b00_1100_0110;
    full_pat  = 10'b00_0011_1000;
    for (int c = 0; c < 9; c++) begin
      full_flag = full_pat[c];
      @(negedge clk);
      checks++;
      if (w_enbl !== exp_wen[c]
          || req_ack !== (exp_wen[c] ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL full_wen c%0d: wen=%b ack=%b want %b",
                 c, w_enbl, req_ack, exp_wen[c]);
      end
      if (c >= 1 && c <= 7) begin
        checks++;
        if (owner !== 2'd2 || busy !== 1'b1 || data_in !== 8'h2C) begin
          errors++;
          $display("FAIL full_own c%0d: own=%0d busy=%b d=%h want 2/1/2c",
                   c, owner, busy, data_in);
        end
      end
      if (c == 8) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL full_end: busy=%b want 0", busy);
        end
        req_valid = '0;
      end
      next_cycle();
    end
    full_flag = 1'b0;
  endtask

  task automatic test_drop_valid();
    do_reset();
    req_data  = 32'hD3_00_D1_00;
    req_valid = 4'b0010;
    next_cycle();
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0010 || data_in !== 8'hD1) begin
      errors++;
      $display("FAIL drop_first: ack=%b d=%h want 0010/d1", req_ack, data_in);
    end
    next_cycle();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (w_enbl !== 1'b0 || req_ack !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_nowr: wen=%b ack=%b busy=%b want 0/0000/1",
               w_enbl, req_ack, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || w_enbl !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: busy=%b wen=%b want 0/0", busy, w_enbl);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (owner !== 2'd3 || req_ack !== 4'b1000 || data_in !== 8'hD3) begin
      errors++;
      $display("FAIL drop_regrant: own=%0d ack=%b d=%h want 3/1000/d3",
               owner, req_ack, data_in);
    end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0100;
    next_cycle();
    next_cycle();
    next_cycle();
    rstn      = 1'b0;
    req_valid = 4'b0101;
    @(negedge clk);
    checks++;
    if (w_enbl !== 1'b0 || req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_gate: wen=%b ack=%b want 0/0000", w_enbl, req_ack);
    end
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b own=%0d want 0/0", busy, owner);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (owner !== 2'd0 || req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_grant: own=%0d ack=%b want 0/0001", owner, req_ack);
    end
    next_cycle();
    req_valid = '0;
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    int words;
    int cyc;
    do_reset();
    @(negedge clk);
    checks++;
    if (stat_cnt !== 64'd0) begin
      errors++;
      $display("FAIL stat_clear: got %h want 0", stat_cnt);
    end
    next_cycle();
    req_valid = 4'b0010;
    words = 0;
    cyc   = 0;
    while (words < 66000 && cyc < 90000) begin
      @(negedge clk);
      if (w_enbl) words++;
      cyc++;
      next_cycle();
    end
    req_valid = '0;
    checks++;
    if (words < 66000) begin
      errors++;
      $display("FAIL stat_timeout: words=%0d want 66000", words);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (stat_cnt !== 64'h0000_0000_FFFF_0000) begin
      errors++;
      $display("FAIL stat_sat: got %h want 00000000ffff0000", stat_cnt);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_stream();
    test_back_to_back();
    test_full_stall();
    test_drop_valid();
    test_reset_mid_burst();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
